// File: rtl/irq_vector_pkg.sv
// irq_vector_pkg: shared sizes, FSM state type and the 8-to-3 priority select
// used by the interrupt vector front end.
package irq_vector_pkg;

    localparam int IRQ_N = 8;
    localparam int VEC_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Highest set index wins; an all-zero input also reports index 0, so
    // callers must qualify the result with a non-zero check.
    function automatic logic [VEC_W-1:0] prio_sel(input logic [IRQ_N-1:0] req);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (req[i]) begin
                idx = i[VEC_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect: turns raw request lines into per-cycle set pulses.
// Build option IRQ_LEVEL_MODE_EN: when defined, requests are level-sensitive
// (set_vec follows irq_in directly and no history register exists); when
// undefined, only a rising edge on a line produces a set pulse.
module irq_edge_detect
    import irq_vector_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_N-1:0] irq_in,
    output logic [IRQ_N-1:0] set_vec
);

`ifdef IRQ_LEVEL_MODE_EN
    // Level mode keeps no history, so clock and reset are not consumed.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign set_vec = irq_in;
`else
    logic [IRQ_N-1:0] irq_q;

    // Previous-cycle copy of the request lines for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_in;
        end
    end

    assign set_vec = irq_in & ~irq_q;
`endif

endmodule

// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl: captures requests into a pending register, gates them with
// an enable mask and offers the highest-index eligible request as a 3-bit
// vector.
// Handshake: vec_valid/vec_id are offered from a register and held stable
// until the cycle vec_ack=1 is sampled while offering; that edge drops
// vec_valid and clears the serviced pending bit, and the next offer can only
// appear one cycle later (one-cycle bubble). vec_ack outside an offer is
// ignored. There is no pre-emption or withdrawal of an offer.
// Build option IRQ_LEVEL_MODE_EN selects level-sensitive requests (see
// irq_edge_detect); the default build is edge-triggered.
module irq_vector_ctrl
    import irq_vector_pkg::*;
#(
    parameter logic [IRQ_N-1:0] RST_MASK = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_N-1:0] irq_in,
    input  logic             mask_we,
    input  logic [IRQ_N-1:0] mask_wdata,
    output logic [IRQ_N-1:0] mask,
    output logic [IRQ_N-1:0] pending,
    output logic             vec_valid,
    output logic [VEC_W-1:0] vec_id,
    input  logic             vec_ack
);

    state_t           state;
    logic [IRQ_N-1:0] set_vec;
    logic [IRQ_N-1:0] eligible;
    logic [IRQ_N-1:0] clr;

    irq_edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .set_vec (set_vec)
    );

    assign eligible = pending & mask;

    // Clear strobe for the request being acknowledged this cycle.
    always_comb begin
        clr = '0;
        if (state == OFFER && vec_ack) begin
            clr[vec_id] = 1'b1;
        end
    end

    // Pending capture (a set beats a same-cycle clear) and mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mask    <= RST_MASK;
        end else begin
            pending <= set_vec | (pending & ~clr);
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // Offer FSM: latch the winner in IDLE, hold it untouched until acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
            vec_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (eligible != '0) begin
                        vec_id    <= prio_sel(eligible);
                        vec_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (vec_ack) begin
                        vec_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    vec_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// tb_irq_vector_ctrl: directed vector table, asynchronous reset during an
// offer, and a randomized run against a cycle-level reference model.
module tb_irq_vector_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       vec_valid;
    logic [2:0] vec_id;
    logic       vec_ack;

    int checks;
    int errors;

    irq_vector_ctrl #(.RST_MASK(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .vec_valid  (vec_valid),
        .vec_id     (vec_id),
        .vec_ack    (vec_ack)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] irq, input logic we, input logic [7:0] wd, input logic ack);
        irq_in     = irq;
        mask_we    = we;
        mask_wdata = wd;
        vec_ack    = ack;
    endtask

    // ---------------- reference model ----------------
    // Offer is tracked as "which request is currently being offered" (-1 for
    // none); everything else is plain bit arithmetic on ints.
    int m_pend, m_mask, m_prev, m_offer, m_id;

    function automatic int highest(input int v);
        for (int i = 7; i >= 0; i--) begin
            if (((v >> i) & 1) == 1) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = 0;
        m_mask  = 'hFF;
        m_prev  = 0;
        m_offer = -1;
        m_id    = 0;
    endtask

    task automatic model_edge(input int irq, input int we, input int wd, input int ack);
        int rises, cleared, nxt_offer;
`ifdef IRQ_LEVEL_MODE_EN
        rises = irq;
`else
        rises = irq & ~m_prev & 'hFF;
`endif
        cleared = (m_offer >= 0 && ack != 0) ? (1 << m_offer) : 0;
        nxt_offer = m_offer;
        if (m_offer >= 0) begin
            if (ack != 0) nxt_offer = -1;
        end else begin
            nxt_offer = highest(m_pend & m_mask);
            if (nxt_offer >= 0) m_id = nxt_offer;
        end
        m_offer = nxt_offer;
        m_pend  = (rises | (m_pend & ~cleared)) & 'hFF;
        if (we != 0) m_mask = wd & 'hFF;
        m_prev  = irq;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] irq;
        logic       we;
        logic [7:0] wd;
        logic       ack;
        logic [7:0] exp_pend;
        logic [7:0] exp_mask;
        logic       exp_valid;
        logic [2:0] exp_id;
    } vec_t;

    vec_t tbl[31];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(8'h00, 1'b0, 8'h00, 1'b0);

        // reset state
        #12;
        check("rst_pending", pending, 8'h00);
        check("rst_mask", mask, 8'hFF);
        check("rst_valid", {7'd0, vec_valid}, 8'h00);
        check("rst_id", {5'd0, vec_id}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifndef IRQ_LEVEL_MODE_EN
        //         irq    we    wd     ack   pend   mask   vld  id
        tbl[0]  = '{8'h20, 1'b0, 8'h00, 1'b0, 8'h20, 8'hFF, 1'b0, 3'd0};
        tbl[1]  = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h20, 8'hFF, 1'b1, 3'd5};
        tbl[2]  = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd5};
        tbl[3]  = '{8'h42, 1'b0, 8'h00, 1'b1, 8'h42, 8'hFF, 1'b0, 3'd5};
        tbl[4]  = '{8'h42, 1'b0, 8'h00, 1'b1, 8'h42, 8'hFF, 1'b1, 3'd6};
        tbl[5]  = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 8'hFF, 1'b0, 3'd6};
        tbl[6]  = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 8'hFF, 1'b1, 3'd1};
        tbl[7]  = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd1};
        tbl[8]  = '{8'h04, 1'b0, 8'h00, 1'b0, 8'h04, 8'hFF, 1'b0, 3'd1};
        tbl[9]  = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h04, 8'hFF, 1'b1, 3'd2};
        tbl[10] = '{8'h80, 1'b0, 8'h00, 1'b0, 8'h84, 8'hFF, 1'b1, 3'd2};
        tbl[11] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h84, 8'hFF, 1'b1, 3'd2};
        tbl[12] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h80, 8'hFF, 1'b0, 3'd2};
        tbl[13] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h80, 8'hFF, 1'b1, 3'd7};
        tbl[14] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd7};
        tbl[15] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd7};
        tbl[16] = '{8'h08, 1'b0, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0, 3'd7};
        tbl[17] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0, 3'd7};
        tbl[18] = '{8'h00, 1'b1, 8'h08, 1'b0, 8'h08, 8'h08, 1'b0, 3'd7};
        tbl[19] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
        tbl[20] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h08, 1'b0, 3'd3};
        tbl[21] = '{8'h10, 1'b1, 8'hFF, 1'b0, 8'h10, 8'hFF, 1'b0, 3'd3};
        tbl[22] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 8'hFF, 1'b1, 3'd4};
        tbl[23] = '{8'h10, 1'b0, 8'h00, 1'b1, 8'h10, 8'hFF, 1'b0, 3'd4};
        tbl[24] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h10, 8'hFF, 1'b1, 3'd4};
        tbl[25] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0, 3'd4};
        tbl[26] = '{8'h01, 1'b0, 8'h00, 1'b0, 8'h01, 8'hFF, 1'b0, 3'd4};
        tbl[27] = '{8'h00, 1'b0, 8'h00, 1'b0, 8'h01, 8'hFF, 1'b1, 3'd0};
        tbl[28] = '{8'h00, 1'b1, 8'h00, 1'b0, 8'h01, 8'h00, 1'b1, 3'd0};
        tbl[29] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
        tbl[30] = '{8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd0};

        for (int r = 0; r < 31; r++) begin
            drive(tbl[r].irq, tbl[r].we, tbl[r].wd, tbl[r].ack);
            tick();
            check($sformatf("tbl%0d_pending", r), pending, tbl[r].exp_pend);
            check($sformatf("tbl%0d_mask", r), mask, tbl[r].exp_mask);
            check($sformatf("tbl%0d_valid", r), {7'd0, vec_valid}, {7'd0, tbl[r].exp_valid});
            check($sformatf("tbl%0d_id", r), {5'd0, vec_id}, {5'd0, tbl[r].exp_id});
        end
`else
        // level mode: a held line is re-offered after every ack
        drive(8'h01, 1'b0, 8'h00, 1'b1);
        tick();
        check("lvl_pend1", pending, 8'h01);
        tick();
        check("lvl_offer1", {7'd0, vec_valid}, 8'h01);
        check("lvl_id1", {5'd0, vec_id}, 8'h00);
        tick();
        check("lvl_bubble", {7'd0, vec_valid}, 8'h00);
        check("lvl_pend_kept", pending, 8'h01);
        tick();
        check("lvl_offer2", {7'd0, vec_valid}, 8'h01);
        drive(8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        check("lvl_drained", pending, 8'h00);
`endif

        // asynchronous reset while an offer is active
        drive(8'h00, 1'b1, 8'h7F, 1'b0);
        tick();
        drive(8'h02, 1'b0, 8'h00, 1'b0);
        tick();
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check("pre_rst_valid", {7'd0, vec_valid}, 8'h01);
        check("pre_rst_id", {5'd0, vec_id}, 8'h01);
        check("pre_rst_mask", mask, 8'h7F);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {7'd0, vec_valid}, 8'h00);
        check("arst_pending", pending, 8'h00);
        check("arst_id", {5'd0, vec_id}, 8'h00);
        check("arst_mask", mask, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_valid", {7'd0, vec_valid}, 8'h00);

        // randomized run against the reference model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] r_irq;
            logic       r_we;
            logic [7:0] r_wd;
            logic       r_ack;
            r_irq = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : irq_in & 8'($urandom_range(0, 255));
            r_we  = ($urandom_range(0, 15) == 0);
            r_wd  = 8'($urandom_range(0, 255));
            r_ack = 1'($urandom_range(0, 1));
            drive(r_irq, r_we, r_wd, r_ack);
            model_edge(int'(r_irq), int'(r_we), int'(r_wd), int'(r_ack));
            tick();
            check("rnd_pending", pending, 8'(m_pend));
            check("rnd_mask", mask, 8'(m_mask));
            check("rnd_valid", {7'd0, vec_valid}, {7'd0, (m_offer >= 0)});
            if (m_offer >= 0) begin
                check("rnd_id", {5'd0, vec_id}, 8'(m_id));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
